// File: rtl/mos_host_driver.sv
`default_nettype none
// ============================================================================
//  Module   : mos_host_driver
//  Purpose  : Host-side driver/collector for the systolic matrix-multiply
//             engine. Buffers operands A and B, streams them to the engine
//             as one contiguous burst, captures the 2N-1 anti-diagonal
//             result beats and exposes them on a combinational read port.
//  Options  : MOS_DRV_CHKSUM_EN - builds the running result checksum;
//             when undefined chksum is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module mos_host_driver #(
    parameter int DATA_W      = 16,
    parameter int RES_W       = 40,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [6:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              size_sel,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              err_proto,
    input  logic [3:0]        rd_addr,
    output logic [RES_W-1:0]  rd_data,
    output logic [RES_W-1:0]  chksum,
    output logic              dut_matrix_size,
    output logic              dut_in_valid,
    output logic [DATA_W-1:0] dut_in_data,
    input  logic              dut_out_valid,
    input  logic [RES_W-1:0]  dut_out_data
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   op_buf [128];
    logic [RES_W-1:0]    result [15];
    logic                size_q;      // latched size: 1 = 8x8
    logic [7:0]          beat_cnt;    // index of the next beat to emit
    logic [3:0]          res_idx;     // next result slot to fill
    logic [WAIT_W-1:0]   wait_cnt;

    logic                idle_like;
    logic                wr_acc;
    logic                start_acc;
    logic                capture;
    logic [7:0]          beat_total;
    logic [3:0]          last_idx;
    logic [DATA_W-1:0]   first_beat;

    // DONE behaves like IDLE for the host: busy is already low there
    assign idle_like  = (state == ST_IDLE) || (state == ST_DONE);
    assign wr_acc     = wr_en && idle_like;
    assign start_acc  = start && idle_like;
    assign capture    = dut_out_valid && ((state == ST_WAIT) || (state == ST_RECV));
    assign beat_total = size_q ? 8'd128 : 8'd32;
    assign last_idx   = size_q ? 4'd14 : 4'd6;
    // Beat 0 is A[0][0]; a same-cycle write to it must reach the burst
    assign first_beat = (wr_acc && (wr_addr == 7'd0)) ? wr_data : op_buf[0];

    // Map a beat index to a buffer address. In 8x8 mode the beat index is
    // the address itself; in 4x4 mode row/col are spread onto the 8-wide grid.
    function automatic logic [6:0] beat_addr(input logic size8, input logic [6:0] k);
        if (size8)
            return k;
        else
            return {k[4], 1'b0, k[3:2], 1'b0, k[1:0]};
    endfunction

    // Operand buffer: host writes only while the driver is not busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) op_buf[i] <= '0;
        end else if (wr_acc) begin
            op_buf[wr_addr] <= wr_data;
        end
    end

    // Transaction sequencer: launch, stream, wait, collect, finish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            size_q          <= 1'b0;
            beat_cnt        <= '0;
            res_idx         <= '0;
            wait_cnt        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_timeout     <= 1'b0;
            err_proto       <= 1'b0;
            dut_matrix_size <= 1'b0;
            dut_in_valid    <= 1'b0;
            dut_in_data     <= '0;
            for (int i = 0; i < 15; i++) result[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    // A result beat outside a collection window is a protocol error
                    if (dut_out_valid) err_proto <= 1'b1;
                    if (start_acc) begin
                        size_q          <= size_sel;
                        busy            <= 1'b1;
                        err_timeout     <= 1'b0;
                        err_proto       <= 1'b0;
                        for (int i = 0; i < 15; i++) result[i] <= '0;
                        dut_in_valid    <= 1'b1;
                        dut_in_data     <= first_beat;
                        dut_matrix_size <= size_sel;
                        beat_cnt        <= 8'd1;
                        state           <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (dut_out_valid) err_proto <= 1'b1;
                    dut_matrix_size <= 1'b0;
                    if (beat_cnt == beat_total) begin
                        dut_in_valid <= 1'b0;
                        dut_in_data  <= '0;
                        wait_cnt     <= '0;
                        state        <= ST_WAIT;
                    end else begin
                        dut_in_data <= op_buf[beat_addr(size_q, beat_cnt[6:0])];
                        beat_cnt    <= beat_cnt + 8'd1;
                    end
                end
                ST_WAIT: begin
                    if (dut_out_valid) begin
                        result[0] <= dut_out_data;
                        res_idx   <= 4'd1;
                        state     <= ST_RECV;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RECV: begin
                    if (dut_out_valid) begin
                        result[res_idx] <= dut_out_data;
                        if (res_idx == last_idx) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            res_idx <= res_idx + 4'd1;
                        end
                    end else begin
                        // Engine stopped early: keep the partial results
                        err_proto <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result read port; indices beyond the current result length read 0
    always_comb begin
        rd_data = '0;
        if (rd_addr <= last_idx) rd_data = result[rd_addr];
    end

`ifdef MOS_DRV_CHKSUM_EN
    // Running wrap-around sum of every captured result beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            chksum <= '0;
        else if (start_acc)
            chksum <= '0;
        else if (capture)
            chksum <= chksum + dut_out_data;
    end
`else
    logic unused_capture;
    assign unused_capture = capture;
    assign chksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mos_host_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mos_host_driver
//  Purpose  : Self-checking bench for mos_host_driver with a behavioural
//             engine and a matrix-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mos_host_driver;

    localparam int DATA_W = 16;
    localparam int RES_W  = 40;
    localparam int TO_CYC = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [6:0]        wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              start = 1'b0;
    logic              size_sel = 1'b0;
    logic              busy, done, err_timeout, err_proto;
    logic [3:0]        rd_addr = '0;
    logic [RES_W-1:0]  rd_data, chksum;
    logic              dut_matrix_size, dut_in_valid;
    logic [DATA_W-1:0] dut_in_data;
    logic              dut_out_valid = 1'b0;
    logic [RES_W-1:0]  dut_out_data = '0;

    mos_host_driver #(.DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .size_sel(size_sel), .busy(busy), .done(done),
        .err_timeout(err_timeout), .err_proto(err_proto), .rd_addr(rd_addr),
        .rd_data(rd_data), .chksum(chksum), .dut_matrix_size(dut_matrix_size),
        .dut_in_valid(dut_in_valid), .dut_in_data(dut_in_data),
        .dut_out_valid(dut_out_valid), .dut_out_data(dut_out_data)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    logic [DATA_W-1:0] mem [128];      // host view of the operand buffer
    logic [DATA_W-1:0] beats [$];      // captured stream
    logic              msz [$];        // matrix_size seen on each beat
    logic [RES_W-1:0]  exp_res [15];   // reference anti-diagonal sums
    logic [RES_W-1:0]  eng_res [15];   // what the behavioural engine returns

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1, returns at posedge+1
    task automatic host_write(input int a, input logic [DATA_W-1:0] d);
        wr_en = 1'b1; wr_addr = 7'(a); wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        mem[a] = d;
    endtask

    // Reference: C = A*B over the host buffer, then sum each anti-diagonal
    function automatic void ref_model(input int n);
        longint acc [15];
        for (int d = 0; d < 15; d++) acc[d] = 0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                for (int k = 0; k < n; k++)
                    acc[r+c] += longint'($signed(mem[r*8+k])) * longint'($signed(mem[64+k*8+c]));
        for (int d = 0; d < 15; d++) exp_res[d] = acc[d][RES_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] beat_at(input int i);
        if (i < beats.size()) return beats[i];
        return '0;
    endfunction

    // Behavioural engine: multiplies whatever matrices arrived on the stream
    function automatic void engine_calc(input int n);
        longint acc [15];
        for (int d = 0; d < 15; d++) acc[d] = 0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                for (int k = 0; k < n; k++)
                    acc[r+c] += longint'($signed(beat_at(r*n+k))) * longint'($signed(beat_at(n*n+k*n+c)));
        for (int d = 0; d < 15; d++) eng_res[d] = acc[d][RES_W-1:0];
    endfunction

    // One full transaction. nret: result beats the engine returns (0 = silent).
    task automatic run_txn(input int n, input int nret, input int delay,
                           input bit same_wr, input bit inject_send, input bit pulse_send);
        int L, nn, c, done_at, done_cnt, cap, ia, busy_at_done;
        logic [DATA_W-1:0] v, expd;
        logic [RES_W-1:0]  e, sum;
        L = 2*n - 1; nn = n*n;
        beats.delete(); msz.delete();
        start = 1'b1; size_sel = (n == 8);
        if (same_wr) begin
            v = DATA_W'($urandom);
            wr_en = 1'b1; wr_addr = 7'd0; wr_data = v; mem[0] = v;
        end
        ref_model(n);
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        check_val("busy_after_start", busy, 1);
        // collect the burst
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dut_in_valid) begin
                beats.push_back(dut_in_data);
                msz.push_back(dut_matrix_size);
                if (inject_send && beats.size() == 5) begin
                    wr_en = 1'b1; wr_addr = 7'd1; wr_data = ~mem[1]; start = 1'b1;
                end else begin
                    wr_en = 1'b0; start = 1'b0;
                end
                if (pulse_send && beats.size() == 3) begin
                    dut_out_valid = 1'b1; dut_out_data = RES_W'($urandom);
                end else begin
                    dut_out_valid = 1'b0; dut_out_data = '0;
                end
            end else if (beats.size() > 0) begin
                break;
            end
        end
        wr_en = 1'b0; start = 1'b0; dut_out_valid = 1'b0;
        check_val("beat_count", beats.size(), 2*nn);
        check_val("idle_in_data", dut_in_data, 0);
        check_val("idle_msize", dut_matrix_size, 0);
        check_val("busy_in_wait", busy, 1);
        for (int k = 0; k < 2*nn && k < beats.size(); k++) begin
            if (k < nn) ia = (k/n)*8 + k%n;
            else        ia = 64 + ((k-nn)/n)*8 + (k-nn)%n;
            expd = mem[ia];
            check_val($sformatf("beat[%0d]", k), beats[k], expd);
            check_val($sformatf("msize[%0d]", k), msz[k], (k == 0) ? (n == 8) : 0);
        end
        // engine response, counted from the first WAIT cycle
        engine_calc(n);
        c = 0; done_at = -1; done_cnt = 0; busy_at_done = 1;
        while (c < 200) begin
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin done_at = c; busy_at_done = busy; end
            end
            if (done_at >= 0 && c >= done_at + 2 && c >= delay + nret + 1) break;
            if (c >= delay && c < delay + nret) begin
                dut_out_valid = 1'b1; dut_out_data = eng_res[(c-delay) % 15];
            end else begin
                dut_out_valid = 1'b0; dut_out_data = '0;
            end
            @(negedge clk); c++;
        end
        dut_out_valid = 1'b0; dut_out_data = '0;
        check_val("done_seen", done_at >= 0, 1);
        check_val("done_pulse_width", done_cnt, 1);
        check_val("busy_at_done", busy_at_done, 0);
        if (nret == 0) check_val("timeout_latency", done_at, TO_CYC);
        check_val("err_timeout", err_timeout, nret == 0);
        check_val("err_proto", err_proto, pulse_send || (nret > 0 && nret != L));
        cap = (nret < L) ? nret : L;
        sum = '0;
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i); #1;
            e = (i < cap) ? exp_res[i] : '0;
            if (i < cap) sum = sum + exp_res[i];
            check_val($sformatf("rd_data[%0d]", i), rd_data, e);
        end
`ifdef MOS_DRV_CHKSUM_EN
        check_val("chksum", chksum, sum);
`else
        check_val("chksum", chksum, 0);
`endif
        @(posedge clk); #1;
    endtask

    initial begin : main
        int exp4 [7];
        int n;
        exp4 = '{1, 7, 18, 34, 33, 27, 16};
        for (int i = 0; i < 128; i++) mem[i] = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_errs", {err_timeout, err_proto}, 0);
        check_val("rst_stream", {dut_in_valid, dut_matrix_size}, 0);
        check_val("rst_in_data", dut_in_data, 0);
        check_val("rst_chksum", chksum, 0);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i); #1;
            check_val("rst_rd_data", rd_data, 0);
        end

        // 4x4 stream order
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                host_write(r*8+c, 16'(r*4+c));
                host_write(64+r*8+c, 16'(100+r*4+c));
            end
        run_txn(4, 7, 3, 0, 0, 0);

        // 4x4 identity end-to-end against fixed sums
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                host_write(r*8+c, (r == c) ? 16'd1 : 16'd0);
                host_write(64+r*8+c, 16'(r*4+c+1));
            end
        run_txn(4, 7, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            rd_addr = 4'(i); #1;
            check_val("ident4_sum", rd_data, 40'(exp4[i]));
        end
`ifdef MOS_DRV_CHKSUM_EN
        check_val("ident4_chksum", chksum, 136);
`endif
        @(posedge clk); #1;

        // 8x8 identity times ones
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                host_write(r*8+c, (r == c) ? 16'd1 : 16'd0);
                host_write(64+r*8+c, 16'd1);
            end
        run_txn(8, 15, 5, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            rd_addr = 4'(i); #1;
            check_val("ones8_sum", rd_data, 40'((i < 8) ? i + 1 : 15 - i));
        end
        @(posedge clk); #1;

        // timeout, truncated response, stray beat in SEND, trailing beat
        run_txn(4, 0, 0, 0, 0, 0);
        run_txn(4, 5, 2, 0, 0, 0);
        run_txn(4, 7, 1, 0, 0, 1);
        run_txn(4, 8, 0, 0, 0, 0);

        // writes and start during SEND are ignored; next run checks buffer
        run_txn(4, 7, 0, 0, 1, 0);
        run_txn(4, 7, 4, 0, 0, 0);

        // randomized operands and sizes
        for (int it = 0; it < 4; it++) begin
            for (int a = 0; a < 128; a++) host_write(a, DATA_W'($urandom));
            n = ($urandom_range(0, 1) == 1) ? 8 : 4;
            run_txn(n, 2*n-1, int'($urandom_range(0, 15)), it[0], 0, 0);
        end

        // asynchronous reset in the middle of the burst
        start = 1'b1; size_sel = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check_val("pre_rst_valid", dut_in_valid, 1);
        rst_n = 1'b0; #1;
        check_val("async_rst_valid", dut_in_valid, 0);
        check_val("async_rst_busy", busy, 0);
        check_val("async_rst_flags", {done, err_timeout, err_proto}, 0);
        for (int i = 0; i < 128; i++) mem[i] = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int a = 0; a < 128; a += 3) host_write(a, DATA_W'($urandom));
        run_txn(4, 7, 2, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
